bus_mem_responder: RTL and testbench
====================================

// Module: bus_mem_responder
// PURPOSE
//  Memory-mapped 32-bit slave (responder) at the far end of the CPU's read/write/byteenable/waitrequest bus.
//  Accepts one read or write at a time from the CPU bus master and stalls it with waitrequest for a set number of wait states.
//  Applies byte-lane writes and returns word reads. Used as instruction+data memory in CPU benches and as the on-chip RAM model.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words stored
//  BASE_ADDR    32'hBFC00000  byte address of word 0 (covers the MIPS reset vector)
//  WAIT_CYCLES  2             fixed wait states inserted before each acknowledge (0..15)
//  LFSR_SEED    8'hA5         nonzero seed for random wait-state generator (used only with BUS_MEM_RANDWAIT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  address      in   32  byte address from master; bits [1:0] ignored
//  read         in   1   read request, held until acknowledged
//  write        in   1   write request, held until acknowledged
//  byteenable   in   4   lane enables; bit i selects writedata[8i+7:8i]
//  writedata    in   32  write data
//  readdata     out  32  read data, valid in acknowledge cycle
//  waitrequest  out  1   high = master must hold request; low for exactly one cycle = transfer complete
//  err          out  1   one-cycle flag in acknowledge cycle: out-of-range address or read&write together
// BEHAVIOUR
//  - States: IDLE, WAIT, ACK. Reset: state=IDLE, count=0, readdata=0, err=0, waitrequest=1; memory contents not cleared.
//  - waitrequest = (state != ACK). It stays high while idle; the master must not treat idle-high as an error.
//  - IDLE: if (read|write) sampled high, latch address/byteenable/writedata/op and load count=WAIT_CYCLES (+rand, see CONFIGURATION).
//    Next state is ACK if count==0, else WAIT.
//  - WAIT: count decrements each cycle; at count==1 go ACK. If read and write are both low (master abort), return to IDLE with no access.
//  - Entering ACK: a read loads readdata <= mem[idx] on that edge, so readdata is registered and stable throughout ACK.
//    A write updates enabled lanes on the edge that leaves ACK. ACK -> IDLE unconditionally.
//  - Latency: request seen at edge N -> ACK (waitrequest=0) during cycle N+1+WAIT_CYCLES.
//    Back-to-back requests cost one extra IDLE cycle each.
//  - Address decoding: idx = (address - BASE_ADDR) >> 2.
//    Out of range when address < BASE_ADDR or idx >= DEPTH_WORDS: read returns 32'h0, write is dropped, err=1 in ACK.
//  - read&write both high: treated as illegal; no memory change, readdata=0, err=1, still acknowledged.
//  - byteenable==0 on write: acknowledged, no change, err=0. Reads ignore byteenable and always return the full word.
//  - readdata holds its value outside ACK until the next read ACK. err is 0 outside ACK.
//  - Reset mid-operation: request discarded, pending write not committed, outputs return to reset values asynchronously.
//  - Inputs are sampled only in IDLE. Changes to the latched fields during WAIT are ignored.
// CONFIGURATION
//  - BUS_MEM_RANDWAIT_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with LFSR_SEED on reset steps every clock.
//    The load in IDLE uses count = WAIT_CYCLES + lfsr[1:0], giving 0..3 extra stalls.
//  - BUS_MEM_RANDWAIT_EN undefined: no LFSR logic; count = WAIT_CYCLES exactly.
// STRUCTURE
//  - Package bus_mem_pkg: state enum (IDLE/WAIT/ACK), OP_READ/OP_WRITE codes, WORD_W=32, BE_W=4.
//  - Sub-module bus_mem_lfsr (8-bit, seed parameter, enable input), instantiated only under BUS_MEM_RANDWAIT_EN.
//  - Storage is a reg array written per lane. Optional $readmemh initialisation is handled by the bench, not this block.
// TESTING
//  1. WAIT_CYCLES=2: write 32'hDEADBEEF, be=4'hF @BFC00000, then read it back.
//     -> waitrequest low in 3rd cycle after request, readdata=DEADBEEF, err=0.
//  2. Word holds 32'h11223344. Write be=4'b0100, writedata=32'hAABBCCDD.
//     -> subsequent read returns 32'h11BB3344.
//  3. Read @BFBFFFFC and @BASE+4*DEPTH_WORDS.
//     -> readdata=0, err=1 in ACK. A write there leaves all words unchanged.
//  4. read=write=1 @BFC00004.
//     -> acknowledged, err=1, memory unchanged. WAIT_CYCLES=0 read -> ACK in the cycle after the request.
//  5. Assert reset during WAIT of a write.
//     -> waitrequest=1, readdata=0 immediately. Word unchanged after reset release.
//  6. BUS_MEM_RANDWAIT_EN, 200 random reads.
//     -> every stall is within WAIT_CYCLES+1..WAIT_CYCLES+4 cycles and data is correct.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus_mem_responder memory slave.
package bus_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Op code is {write, read} as sampled; both bits set is the illegal combination.
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_BOTH  = 2'b11;

endpackage

// File: rtl/bus_mem_if.sv
// Read/write/byteenable/waitrequest bus between a CPU master and a memory slave.
import bus_mem_pkg::*;

interface bus_mem_if;
  logic [WORD_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [WORD_W-1:0] writedata;
  logic [WORD_W-1:0] readdata;
  logic              waitrequest;
  logic              err;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest, err
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest, err
  );
endinterface

// File: rtl/bus_mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise wait states.
module bus_mem_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  output logic [7:0] o_lfsr
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Word-addressed RAM slave with fixed (or, with BUS_MEM_RANDWAIT_EN, randomised)
// wait states, byte-lane writes and a one-cycle err flag on bad accesses.
//
// state | meaning
// IDLE  | waiting for read/write; request fields latched here
// WAIT  | counting down wait states; abort if master drops request
// ACK   | waitrequest low for one cycle; write commits on the exit edge
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  bus_mem_if.slave bus
);

  localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [4:0]  WAIT_L = 5'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_count;
  logic [4:0]          w_load;
  logic [WORD_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  logic [BE_W-1:0]     r_be;
  logic [1:0]          r_op;
  logic                r_err;
  logic [WORD_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_req;
  logic [WORD_W-1:0]   w_src_addr;
  logic [WORD_W-1:0]   w_off;
  logic [1:0]          w_src_op;
  logic                w_in_range;
  logic                w_bad;
  logic [IDX_W-1:0]    w_idx;

  assign w_req = bus.read | bus.write;

  // In IDLE the decode must look at the live bus so a zero-wait access can
  // enter ACK on the same edge that samples it; afterwards it uses the latch.
  assign w_src_addr = (r_state == IDLE) ? bus.address : r_addr;
  assign w_src_op   = (r_state == IDLE) ? {bus.write, bus.read} : r_op;
  assign w_off      = w_src_addr - BASE_ADDR;
  assign w_in_range = (w_src_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_bad      = (w_src_op == OP_BOTH) || !w_in_range;

`ifdef BUS_MEM_RANDWAIT_EN
  logic [7:0] w_lfsr;

  bus_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  assign w_load = WAIT_L + {3'b000, w_lfsr[1:0]};
`else
  assign w_load = WAIT_L;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = (w_load == 5'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next = IDLE;
        end else if (r_count == 5'd1) begin
          w_next = ACK;
        end
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 5'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_op    <= 2'b00;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.address;
            r_wdata <= bus.writedata;
            r_be    <= bus.byteenable;
            r_op    <= {bus.write, bus.read};
            r_count <= w_load;
          end
        end
        WAIT:    r_count <= r_count - 5'd1;
        default: ;
      endcase
      if (w_next == ACK) begin
        r_err <= w_bad;
        // Any access carrying a read bit refreshes readdata; bad ones read as zero.
        if (w_src_op[0]) begin
          r_rdata <= w_bad ? '0 : r_mem[w_idx];
        end
      end else begin
        r_err <= 1'b0;
      end
    end
  end

  // No reset on storage: contents survive reset like a real RAM.
  always_ff @(posedge clk) begin
    if (r_state == ACK && r_op == OP_WRITE && w_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.waitrequest = (r_state != ACK);
  assign bus.readdata    = r_rdata;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: two instances (2 and 0 wait states).
module tb_bus_mem_responder;
  import bus_mem_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int DEP0 = 1024;
  localparam int DEP1 = 16;
  localparam int W0   = 2;
  localparam int W1   = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bus_mem_if b0 ();
  bus_mem_if b1 ();

  bus_mem_responder #(.DEPTH_WORDS(DEP0), .BASE_ADDR(BASE), .WAIT_CYCLES(W0), .LFSR_SEED(8'hA5))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  bus_mem_responder #(.DEPTH_WORDS(DEP1), .BASE_ADDR(BASE), .WAIT_CYCLES(W1), .LFSR_SEED(8'h3C))
    dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m0 [DEP0];
  logic [31:0] m1 [DEP1];
  logic [31:0] last_rd [2];
  int          stall [2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [31:0] mget(input int d, input int ix);
    return (d == 0) ? m0[ix] : m1[ix];
  endfunction

  task automatic mset(input int d, input int ix, input logic [31:0] v);
    if (d == 0) m0[ix] = v; else m1[ix] = v;
  endtask

  function automatic logic wrq(input int d);
    return (d == 0) ? b0.waitrequest : b1.waitrequest;
  endfunction

  task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (d == 0) begin
      b0.read = rd; b0.write = wr; b0.address = a; b0.byteenable = be; b0.writedata = wd;
    end else begin
      b1.read = rd; b1.write = wr; b1.address = a; b1.byteenable = be; b1.writedata = wd;
    end
  endtask

  // Monitor: one step per DUT per falling edge.
  task automatic mon_step(input int d, input logic req, input logic wr_n,
                          input logic [31:0] rd, input logic er);
    exp_t e;
    int   lo;
    int   hi;
    if (wr_n === 1'b0) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_ack dut%0d: got ack required none", d);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("rdata_dut%0d", d), rd, e.rdata);
        check($sformatf("err_dut%0d", d), {31'b0, er}, {31'b0, e.err});
        lo = wait_of(d) + 1;
`ifdef BUS_MEM_RANDWAIT_EN
        hi = lo + 3;
`else
        hi = lo;
`endif
        total++;
        if (stall[d] < lo || stall[d] > hi) begin
          bad++;
          $display("FAIL stall_dut%0d: got %0d required %0d..%0d", d, stall[d], lo, hi);
        end
      end
      stall[d] = 0;
    end else begin
      check($sformatf("err_idle_dut%0d", d), {31'b0, er}, 32'd0);
      if (req) stall[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_step(0, b0.read | b0.write, b0.waitrequest, b0.readdata, b0.err);
      mon_step(1, b1.read | b1.write, b1.waitrequest, b1.readdata, b1.err);
    end
  end

  // Reference model: byte-addressed window, word = floor(offset/4); called at posedge+1.
  task automatic do_op(input int d, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    exp_t        e;
    longint      off;
    bit          ok;
    int          ix;
    logic [31:0] w;
    bit          done;
    off = longint'(a) - longint'(BASE);
    ok  = (off >= 0) && (off < longint'(depth_of(d)) * 4);
    ix  = ok ? int'(off / 4) : 0;
    if (rd && wr) begin
      e.rdata = 32'h0; e.err = 1'b1; last_rd[d] = 32'h0;
    end else if (rd) begin
      e.err = !ok; e.rdata = ok ? mget(d, ix) : 32'h0; last_rd[d] = e.rdata;
    end else begin
      e.err = !ok; e.rdata = last_rd[d];
      if (ok) begin
        w = mget(d, ix);
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        mset(d, ix, w);
      end
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive(d, rd, wr, a, be, wd);
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wrq(d) === 1'b0) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout_dut%0d addr %h: got no ack required ack", d, a);
      if (d == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    int          k;
    int          sel;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    stall[0] = 0; stall[1] = 0;
    #1;
    check("rst_waitreq0", {31'b0, b0.waitrequest}, 32'd1);
    check("rst_rdata0", b0.readdata, 32'h0);
    check("rst_err0", {31'b0, b0.err}, 32'd0);
    check("rst_waitreq1", {31'b0, b1.waitrequest}, 32'd1);
    check("rst_rdata1", b1.readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEP0; i++) do_op(0, 1'b0, 1'b1, BASE + 32'(4*i), 4'hF, $urandom);
    for (int i = 0; i < DEP1; i++) do_op(1, 1'b0, 1'b1, BASE + 32'(4*i), 4'hF, $urandom);

    do_op(0, 1'b0, 1'b1, BASE, 4'hF, 32'hDEADBEEF);
    do_op(0, 1'b1, 1'b0, BASE, 4'h0, 32'h0);

    do_op(0, 1'b0, 1'b1, BASE + 32'd16, 4'hF, 32'h11223344);
    do_op(0, 1'b0, 1'b1, BASE + 32'd16, 4'b0100, 32'hAABBCCDD);
    do_op(0, 1'b1, 1'b0, BASE + 32'd16, 4'h0, 32'h0);

    do_op(0, 1'b1, 1'b0, 32'hBFBFFFFC, 4'hF, 32'h0);
    do_op(0, 1'b1, 1'b0, BASE + 32'(4*DEP0), 4'hF, 32'h0);
    do_op(0, 1'b0, 1'b1, 32'hBFBFFFFC, 4'hF, 32'h12345678);
    do_op(0, 1'b0, 1'b1, BASE + 32'(4*DEP0), 4'hF, 32'h87654321);
    do_op(0, 1'b1, 1'b0, BASE, 4'h0, 32'h0);
    do_op(0, 1'b1, 1'b0, BASE + 32'(4*(DEP0-1)), 4'h0, 32'h0);
    do_op(0, 1'b0, 1'b1, BASE + 32'd20, 4'h0, 32'hFFFFFFFF);
    do_op(0, 1'b1, 1'b0, BASE + 32'd20, 4'h0, 32'h0);

    do_op(0, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'hCAFEF00D);
    do_op(0, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'h0);

    do_op(1, 1'b1, 1'b0, BASE, 4'h0, 32'h0);
    do_op(1, 1'b1, 1'b0, BASE + 32'(4*(DEP1-1)) + 32'd3, 4'h0, 32'h0);
    do_op(1, 1'b1, 1'b0, BASE + 32'(4*DEP1), 4'h0, 32'h0);
    do_op(1, 1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h0);

    for (int n = 0; n < 240; n++) begin
      k   = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      ra = BASE - 32'($urandom_range(1, 64));
      else if (sel == 1) ra = BASE + 32'(4*depth_of(n % 2)) + 32'($urandom_range(0, 64));
      else               ra = BASE + 32'($urandom_range(0, 4*depth_of(n % 2) - 1));
      do_op(n % 2, (k < 5) || (k == 9), k >= 5, ra, 4'($urandom), $urandom);
    end

    do_op(0, 1'b0, 1'b1, BASE, 4'hF, 32'hDEADBEEF);
    do_op(0, 1'b1, 1'b0, BASE, 4'h0, 32'h0);
    drive(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF, ~m0[2]);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_waitreq", {31'b0, b0.waitrequest}, 32'd1);
    check("midrst_rdata", b0.readdata, 32'h0);
    check("midrst_err", {31'b0, b0.err}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stall[0] = 0; stall[1] = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(0, 1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0);
    do_op(1, 1'b0, 1'b1, BASE + 32'd12, 4'h3, 32'h5A5A5A5A);
    do_op(1, 1'b1, 1'b0, BASE + 32'd12, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
